cbfp_block_norm: RTL
====================

Name: cbfp_block_norm

Overview:
Parametrised convergent block-floating-point normaliser. It generalises the fixed 16-lane, 23-to-11-bit module-0 CBFP stage to any lane count, input/output width and block length, and adds a bypass mode. It collects one block of LANES complex samples per beat over BLK_CYC valid beats and finds the block-wide minimum leading-sign count. It then replays the block shifted, rounded and saturated to DOUT_W, with the shift reported as an exponent. It sits between a butterfly stage (for example step0_2/step1_2 outputs) and the next radix stage.

Parameters:
LANES, 16, complex samples per beat
DIN_W, 23, signed input width (re and im)
DOUT_W, 11, signed output width; must be < DIN_W
BLK_CYC, 4, valid beats per block (64 points / 16 lanes)
EXP_W, 5, exponent width; must satisfy 2^EXP_W > DIN_W-1

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
valid_in  in  1  input beat qualifier; gaps between beats allowed
bypass  in  1  force shift 0; sampled on first beat of each input block
din_re  in  LANES x DIN_W  signed real inputs
din_im  in  LANES x DIN_W  signed imaginary inputs
dout_re  out  LANES x DOUT_W  signed normalised real outputs
dout_im  out  LANES x DOUT_W  signed normalised imaginary outputs
exp_out  out  EXP_W  block shift applied; stable for the whole output block
valid_out  out  1  output beat qualifier
blk_start  out  1  high on first output beat of each block

Behaviour:
- Reset (synchronous, rst=1 at edge): valid_out=0, blk_start=0, dout_*=0, exp_out=0. Write/read pointers, bank-select, running min and bank-full flags are cleared. A partially collected block is discarded.
- Storage: two banks (ping-pong), each BLK_CYC x LANES complex words. The writer fills one bank while the reader drains the other.
- Write: each valid_in beat stores din_* at wr_ptr and increments wr_ptr. The beat with wr_ptr==BLK_CYC-1 completes the block. On completion: wr_ptr wraps to 0, the bank toggles, and the final min and bypass flag are latched into that bank's descriptor.
- Leading-sign count ls(x): number of bits below the MSB equal to the MSB, range 0..DIN_W-1. 0 and -1 both give DIN_W-1; most-negative gives 0.
- Running min: taken over all 2*LANES values of every beat in the block, and reset per block. sh = bypass_latched ? 0 : min.
- Read: the block becomes readable at the edge that samples its last beat. valid_out rises 2 edges later and stays high for exactly BLK_CYC consecutive cycles, regardless of input gaps. blk_start is high on beat 0 only. exp_out = sh, held until the next block's beat 0.
- Output arithmetic per value: y = x <<< sh (no overflow, by construction of sh). q = y >>> (DIN_W-DOUT_W). Add round bit y[DIN_W-DOUT_W-1] (round half-up). Saturate: if the result exceeds 2^(DOUT_W-1)-1, output 2^(DOUT_W-1)-1. Negative overflow is impossible.
- Throughput: continuous valid_in sustains 1 beat/cycle with no overflow, since reader and writer periods are equal. The next block's readout starts the cycle after the previous block's last beat.
- Simultaneous completion and read-finish: the reader moves to the new bank seamlessly, with no bubble.
- valid_in during rst: ignored.

Decomposition:
- Package cbfp_pkg: function lead_sign(x, width); constants for the default widths; a typedef for the bank descriptor struct {min_ls, bypass, full}.
- One sub-module, cbfp_lsc_min: combinational per-beat minimum of ls over 2*LANES values (balanced tree), plus a register stage feeding the running min.

Test Plan:
- Defaults, all 4 beats, all lanes re=im=3 -> exp_out=20, every dout=768, valid_out high 4 cycles starting 2 edges after the last input beat, blk_start on the first beat.
- Same data with bypass=1 -> exp_out=0, all dout=0.
- One lane re=2^21, all others 3 -> exp_out=0; that lane gives 512, others 0.
- One value 4194303, rest 0 -> exp_out=0; that output saturates to 1023. Value -4194304 -> -1024.
- Input beats with valid_in gaps (1,0,1,0,...) -> identical output values, emitted as 4 contiguous valid_out cycles.
- Continuous 3 blocks back-to-back with differing magnitudes -> 12 contiguous valid_out cycles, exp_out changing exactly at each blk_start.
- rst pulsed after beat 2 of a block -> no valid_out for that block; the next full block is processed correctly.

Source files
------------

// File: rtl/cbfp_pkg.sv
// ---------------------------------------------------------------------------
// cbfp_pkg
// Shared definitions for the convergent block-floating-point normaliser:
//   - default widths / block geometry used as parameter defaults
//   - lead_sign(): leading-sign count of a two's-complement value
//   - bank_desc_t: per-bank descriptor (block minimum, bypass, full flag)
// ---------------------------------------------------------------------------
package cbfp_pkg;

   localparam int DEF_LANES   = 16;
   localparam int DEF_DIN_W   = 23;
   localparam int DEF_DOUT_W  = 11;
   localparam int DEF_BLK_CYC = 4;
   localparam int DEF_EXP_W   = 5;

   // Widest value lead_sign() accepts; callers zero-extend into this width.
   localparam int MAX_W       = 64;
   localparam int IDX_W       = 6;

   // Descriptor field wide enough for any supported exponent width.
   localparam int DESC_LS_W   = 8;

   typedef struct packed {
      logic [DESC_LS_W-1:0] min_ls;
      logic                 bypass;
      logic                 full;
   } bank_desc_t;

   // Number of bits directly below the sign bit that repeat the sign bit.
   // Only the low 'width' bits of x are significant. 0 and -1 give width-1,
   // the most-negative value gives 0.
   function automatic logic [7:0] lead_sign(input logic [MAX_W-1:0] x,
                                            input int               width);
      logic [7:0] cnt;
      logic       run;
      logic       msb;
      cnt = 8'd0;
      run = 1'b1;
      msb = x[IDX_W'(width - 1)];
      for (int i = MAX_W - 2; i >= 0; i--) begin
         if (i < width - 1) begin
            if (run && (x[IDX_W'(i)] == msb)) begin
               cnt = cnt + 8'd1;
            end else begin
               run = 1'b0;
            end
         end else begin
            run = run;
         end
      end
      return cnt;
   endfunction

endpackage

// File: rtl/cbfp_lsc_min.sv
// ---------------------------------------------------------------------------
// cbfp_lsc_min
// Per-beat minimum leading-sign count over all 2*LANES values of one beat,
// computed by a balanced comparison tree and registered once.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   valid             beat qualifier
//   din_re, din_im    LANES x DIN_W signed samples
//   beat_min          registered minimum ls of the last qualified beat
//   beat_vld          high the cycle after a qualified beat
// ---------------------------------------------------------------------------
module cbfp_lsc_min
   import cbfp_pkg::*;
#(
   parameter int LANES = DEF_LANES,
   parameter int DIN_W = DEF_DIN_W,
   parameter int EXP_W = DEF_EXP_W
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         valid,
   input  logic [LANES-1:0][DIN_W-1:0]  din_re,
   input  logic [LANES-1:0][DIN_W-1:0]  din_im,
   output logic [EXP_W-1:0]             beat_min,
   output logic                         beat_vld
);

   localparam int NV = 2 * LANES;
   localparam int LV = $clog2(NV);
   // Leaf count padded to a power of two; pad leaves hold the neutral maximum.
   localparam int NP = 1 << LV;
   localparam logic [EXP_W-1:0] LS_MAX = EXP_W'(DIN_W - 1);

   logic [EXP_W-1:0] beat_min_s;
   logic [EXP_W-1:0] beat_min_r;
   logic             beat_vld_r;

   // Heap-ordered min tree: leaves at NP-1.., node n = min(2n+1, 2n+2)
   always_comb begin
      logic [EXP_W-1:0] tree [0:2*NP-2];
      for (int i = 0; i < 2 * NP - 1; i++) begin
         tree[i] = LS_MAX;
      end
      for (int l = 0; l < LANES; l++) begin
         tree[NP - 1 + 2 * l]     = EXP_W'(lead_sign(MAX_W'(din_re[l]), DIN_W));
         tree[NP - 1 + 2 * l + 1] = EXP_W'(lead_sign(MAX_W'(din_im[l]), DIN_W));
      end
      for (int n = NP - 2; n >= 0; n--) begin
         tree[n] = (tree[2 * n + 1] < tree[2 * n + 2]) ? tree[2 * n + 1] : tree[2 * n + 2];
      end
      beat_min_s = tree[0];
   end

   // Register the beat minimum so the running-min compare sees a short path
   always_ff @(posedge clk) begin
      if (rst) begin
         beat_min_r <= LS_MAX;
         beat_vld_r <= 1'b0;
      end else begin
         beat_vld_r <= valid;
         if (valid) begin
            beat_min_r <= beat_min_s;
         end else begin
            beat_min_r <= beat_min_r;
         end
      end
   end

   assign beat_min = beat_min_r;
   assign beat_vld = beat_vld_r;

endmodule

// File: rtl/cbfp_block_norm.sv
// ---------------------------------------------------------------------------
// cbfp_block_norm
// Convergent block-floating-point normaliser. Collects BLK_CYC beats of LANES
// complex samples into one ping-pong bank, tracks the block-wide minimum
// leading-sign count, then replays the block shifted left by that count,
// rounded half-up and saturated to DOUT_W bits, with the shift as exponent.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   valid_in            input beat qualifier (gaps allowed)
//   bypass              force shift 0; sampled on the first beat of a block
//   din_re, din_im      LANES x DIN_W signed inputs
//   dout_re, dout_im    LANES x DOUT_W signed normalised outputs
//   exp_out             shift applied to the current output block
//   valid_out           output beat qualifier
//   blk_start           first output beat of each block
// ---------------------------------------------------------------------------
module cbfp_block_norm
   import cbfp_pkg::*;
#(
   parameter int LANES   = DEF_LANES,
   parameter int DIN_W   = DEF_DIN_W,
   parameter int DOUT_W  = DEF_DOUT_W,
   parameter int BLK_CYC = DEF_BLK_CYC,
   parameter int EXP_W   = DEF_EXP_W
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          valid_in,
   input  logic                          bypass,
   input  logic [LANES-1:0][DIN_W-1:0]   din_re,
   input  logic [LANES-1:0][DIN_W-1:0]   din_im,
   output logic [LANES-1:0][DOUT_W-1:0]  dout_re,
   output logic [LANES-1:0][DOUT_W-1:0]  dout_im,
   output logic [EXP_W-1:0]              exp_out,
   output logic                          valid_out,
   output logic                          blk_start
);

   localparam int PTR_W = (BLK_CYC > 1) ? $clog2(BLK_CYC) : 1;
   localparam int SH_R  = DIN_W - DOUT_W;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BLK_CYC - 1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [EXP_W-1:0] LS_MAX   = EXP_W'(DIN_W - 1);

   // Ping-pong sample storage, indexed [bank][beat]
   logic [LANES-1:0][DIN_W-1:0] mem_re_r [0:1][0:BLK_CYC-1];
   logic [LANES-1:0][DIN_W-1:0] mem_im_r [0:1][0:BLK_CYC-1];

   logic [PTR_W-1:0] wr_ptr_r;
   logic             wr_bank_r;
   logic             byp_cur_r;
   logic             last_r;
   logic             last_bank_r;
   logic [EXP_W-1:0] run_min_r;
   bank_desc_t       desc_r [0:1];
   logic [PTR_W-1:0] rd_ptr_r;
   logic             rd_bank_r;

   logic [EXP_W-1:0]     beat_min_s;
   logic                 beat_vld_s;
   logic                 wr_last_s;
   logic [EXP_W-1:0]     final_min_s;
   bank_desc_t           cur_desc_s;
   logic [DESC_LS_W-1:0] sh_s;
   logic                 rd_go_s;
   logic                 rd_done_s;

   // Shift, round half-up and saturate one value. The shifted word is taken
   // from the round bit upwards: w = {q, round_bit}, q being the DOUT_W-bit
   // truncated result. Only positive overflow can occur (e.g. 2^(DIN_W-1)-1).
   function automatic logic [DOUT_W-1:0] norm_val(input logic [DIN_W-1:0]     x,
                                                  input logic [DESC_LS_W-1:0] sh);
      logic [DOUT_W:0]   w;
      logic [DOUT_W:0]   r;
      logic [DOUT_W-1:0] res;
      w = (DOUT_W + 1)'(({{DIN_W{x[DIN_W-1]}}, x} << sh) >> (SH_R - 1));
      r = {w[DOUT_W], w[DOUT_W:1]} + {{DOUT_W{1'b0}}, w[0]};
      if (!r[DOUT_W] && r[DOUT_W-1]) begin
         res = {1'b0, {(DOUT_W - 1){1'b1}}};
      end else begin
         res = r[DOUT_W-1:0];
      end
      return res;
   endfunction

   cbfp_lsc_min #(
      .LANES (LANES),
      .DIN_W (DIN_W),
      .EXP_W (EXP_W)
   ) u_lsc_min (
      .clk      (clk),
      .rst      (rst),
      .valid    (valid_in),
      .din_re   (din_re),
      .din_im   (din_im),
      .beat_min (beat_min_s),
      .beat_vld (beat_vld_s)
   );

   // Write-side decode, block minimum fold and read-side control
   always_comb begin
      wr_last_s   = valid_in && (wr_ptr_r == LAST_PTR);
      final_min_s = (beat_min_s < run_min_r) ? beat_min_s : run_min_r;
      cur_desc_s  = desc_r[rd_bank_r];
      rd_go_s     = cur_desc_s.full;
      rd_done_s   = rd_go_s && (rd_ptr_r == LAST_PTR);
      if (cur_desc_s.bypass) begin
         sh_s = '0;
      end else begin
         sh_s = cur_desc_s.min_ls;
      end
   end

   // Sample storage; no reset needed, a bank is only read once marked full
   always_ff @(posedge clk) begin
      if (!rst && valid_in) begin
         mem_re_r[wr_bank_r][wr_ptr_r] <= din_re;
         mem_im_r[wr_bank_r][wr_ptr_r] <= din_im;
      end
   end

   // Write pointer, bank select and first-beat bypass capture
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r    <= '0;
         wr_bank_r   <= 1'b0;
         byp_cur_r   <= 1'b0;
         last_r      <= 1'b0;
         last_bank_r <= 1'b0;
      end else begin
         // The block minimum lags the data by one edge, so completion is
         // carried forward to finalise the descriptor alongside it.
         last_r      <= wr_last_s;
         last_bank_r <= wr_bank_r;
         if (valid_in) begin
            if (wr_ptr_r == '0) begin
               byp_cur_r <= bypass;
            end
            if (wr_ptr_r == LAST_PTR) begin
               wr_ptr_r  <= '0;
               wr_bank_r <= ~wr_bank_r;
            end else begin
               wr_ptr_r  <= wr_ptr_r + PTR_ONE;
            end
         end
      end
   end

   // Running block minimum and bank descriptors (set on completion, cleared
   // when the reader finishes the bank)
   always_ff @(posedge clk) begin
      if (rst) begin
         run_min_r <= LS_MAX;
         desc_r[0] <= '0;
         desc_r[1] <= '0;
      end else begin
         if (last_r) begin
            run_min_r                   <= LS_MAX;
            desc_r[last_bank_r].min_ls  <= DESC_LS_W'(final_min_s);
            desc_r[last_bank_r].bypass  <= byp_cur_r;
            desc_r[last_bank_r].full    <= 1'b1;
         end else if (beat_vld_s) begin
            run_min_r <= final_min_s;
         end else begin
            run_min_r <= run_min_r;
         end
         if (rd_done_s) begin
            desc_r[rd_bank_r].full <= 1'b0;
         end
      end
   end

   // Reader: drains a full bank one beat per cycle into registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_r  <= '0;
         rd_bank_r <= 1'b0;
         valid_out <= 1'b0;
         blk_start <= 1'b0;
         exp_out   <= '0;
         dout_re   <= '0;
         dout_im   <= '0;
      end else if (rd_go_s) begin
         valid_out <= 1'b1;
         blk_start <= (rd_ptr_r == '0);
         exp_out   <= EXP_W'(sh_s);
         for (int l = 0; l < LANES; l++) begin
            dout_re[l] <= norm_val(mem_re_r[rd_bank_r][rd_ptr_r][l], sh_s);
            dout_im[l] <= norm_val(mem_im_r[rd_bank_r][rd_ptr_r][l], sh_s);
         end
         if (rd_done_s) begin
            rd_ptr_r  <= '0;
            rd_bank_r <= ~rd_bank_r;
         end else begin
            rd_ptr_r  <= rd_ptr_r + PTR_ONE;
         end
      end else begin
         valid_out <= 1'b0;
         blk_start <= 1'b0;
      end
   end

endmodule
